cva6_lockstep_ctrl: RTL and testbench

// Per-group redundancy controller for NumHarts CVA6 cores, partitioned into NumHarts/GroupSize groups (DMR=2, TMR=3).

---
 rtl/cva6_hmr_pkg.sv | 13 +
 rtl/cva6_lockstep_grp_fsm.sv | 129 ++++++++++++
 rtl/cva6_lockstep_ctrl.sv | 67 ++++++
 tb/tb_cva6_lockstep_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cva6_hmr_pkg.sv
// Shared types for the CVA6 hart-redundancy lockstep controller.
package cva6_hmr_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SETBACK = 2'd1,
      RESYNC  = 2'd2,
      FAIL    = 2'd3
   } grp_state_e;

   localparam logic [1:0] FaultyNone = 2'd3;

endpackage

// File: rtl/cva6_lockstep_grp_fsm.sv
// One lockstep group: signature compare/vote, recovery FSM, shared setback/resync timer, error counter.
//   state   | meaning
//   RUN     | comparing signatures every cycle (when lockstep)
//   SETBACK | holding core setback for SetbackCycles cycles
//   RESYNC  | waiting for all harts to reach the sync point, timeout armed
//   FAIL    | unrecoverable; sticky until reset or lockstep drop
module cva6_lockstep_grp_fsm
   import cva6_hmr_pkg::*;
#(
   parameter int GroupSize     = 2,
   parameter int SigWidth      = 64,
   parameter int SetbackCycles = 8,
   parameter int SyncTimeout   = 1024,
   parameter int CntWidth      = 8
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               lockstep_i,
   input  logic [GroupSize-1:0]               cmp_valid_i,
   input  logic [GroupSize-1:0][SigWidth-1:0] cmp_sig_i,
   input  logic [GroupSize-1:0]               sync_req_i,
   output logic                               setback_o,
   output grp_state_e                         state_o,
   output logic                               error_o,
   output logic [1:0]                         faulty_o,
   output logic                               failure_o,
   output logic [CntWidth-1:0]                cnt_o
);

   localparam int TmrMax = (SetbackCycles > SyncTimeout) ? SetbackCycles : SyncTimeout;
   localparam int TmrW   = $clog2(TmrMax + 1);

   logic [TmrW-1:0] tmr;
   logic            agr [3][3];
   logic            all_agree;
   logic            mismatch;
   logic            no_major;
   logic [1:0]      odd_idx;

   // Pairs agree when valid bits match and, if valid, signatures match; padded to 3 so TMR voting is uniform.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            agr[i][j] = 1'b0;
         end
      end
      all_agree = 1'b1;
      for (int i = 0; i < GroupSize; i++) begin
         for (int j = 0; j < GroupSize; j++) begin
            agr[i][j] = (cmp_valid_i[i] == cmp_valid_i[j]) &&
                        (!cmp_valid_i[i] || (cmp_sig_i[i] == cmp_sig_i[j]));
            if (!agr[i][j]) all_agree = 1'b0;
         end
      end
      mismatch = (|cmp_valid_i) && !all_agree;
      no_major = 1'b0;
      odd_idx  = FaultyNone;
      if (GroupSize == 3) begin
         no_major = !agr[0][1] && !agr[0][2] && !agr[1][2];
         for (int i = 0; i < 3; i++) begin
            if (agr[(i+1)%3][(i+2)%3] && !agr[i][(i+1)%3]) odd_idx = 2'(i);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_o   <= RUN;
         setback_o <= 1'b0;
         error_o   <= 1'b0;
         faulty_o  <= FaultyNone;
         failure_o <= 1'b0;
         cnt_o     <= '0;
         tmr       <= '0;
      end else begin
         error_o <= 1'b0;
         if (!lockstep_i) begin
            state_o   <= RUN;
            setback_o <= 1'b0;
            faulty_o  <= FaultyNone;
            failure_o <= 1'b0;
            tmr       <= '0;
         end else begin
            case (state_o)
               RUN: begin
                  if (mismatch) begin
                     error_o  <= 1'b1;
                     faulty_o <= no_major ? FaultyNone : odd_idx;
                     if (cnt_o != '1) cnt_o <= cnt_o + 1'b1;
                     if (no_major) begin
                        state_o   <= FAIL;
                        failure_o <= 1'b1;
                     end else begin
                        state_o   <= SETBACK;
                        setback_o <= 1'b1;
                        tmr       <= TmrW'(SetbackCycles - 1);
                     end
                  end
               end
               SETBACK: begin
                  if (tmr == '0) begin
                     state_o   <= RESYNC;
                     setback_o <= 1'b0;
                     tmr       <= TmrW'(SyncTimeout - 1);
                  end else begin
                     tmr <= tmr - 1'b1;
                  end
               end
               RESYNC: begin
                  // Sync takes priority over a timeout expiring in the same cycle.
                  if (&sync_req_i) begin
                     state_o <= RUN;
                  end else if (tmr == '0) begin
                     state_o   <= FAIL;
                     failure_o <= 1'b1;
                  end else begin
                     tmr <= tmr - 1'b1;
                  end
               end
               FAIL: begin
                  setback_o <= 1'b0;
               end
               default: state_o <= RUN;
            endcase
         end
      end
   end

endmodule

// File: rtl/cva6_lockstep_ctrl.sv
// Lockstep redundancy controller for NumHarts CVA6 cores split into DMR/TMR groups.
// Slices per-hart ports into groups and flattens the per-group results.
module cva6_lockstep_ctrl
   import cva6_hmr_pkg::*;
#(
   parameter int NumHarts      = 4,
   parameter int GroupSize     = 2,
   parameter int SigWidth      = 64,
   parameter int SetbackCycles = 8,
   parameter int SyncTimeout   = 1024,
   parameter int CntWidth      = 8,
   localparam int NumGrps      = NumHarts / GroupSize
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NumGrps-1:0]           grp_lockstep_i,
   input  logic [NumHarts-1:0]          cmp_valid_i,
   input  logic [NumHarts*SigWidth-1:0] cmp_sig_i,
   input  logic [NumHarts-1:0]          sync_req_i,
   output logic [NumHarts-1:0]          core_setback_o,
   output logic [NumGrps*2-1:0]         grp_state_o,
   output logic [NumGrps-1:0]           grp_error_o,
   output logic [NumGrps*2-1:0]         grp_faulty_o,
   output logic [NumGrps-1:0]           grp_failure_o,
   output logic [NumGrps*CntWidth-1:0]  mismatch_cnt_o
);

   if (GroupSize != 2 && GroupSize != 3) begin : g_bad_group_size
      $error("cva6_lockstep_ctrl: GroupSize must be 2 or 3");
   end
   if (NumHarts % GroupSize != 0) begin : g_bad_num_harts
      $error("cva6_lockstep_ctrl: NumHarts must be a multiple of GroupSize");
   end
   if (SetbackCycles < 1 || SyncTimeout < 1) begin : g_bad_timers
      $error("cva6_lockstep_ctrl: SetbackCycles and SyncTimeout must be >= 1");
   end

   for (genvar g = 0; g < NumGrps; g++) begin : g_grp
      grp_state_e state;
      logic       setback;

      cva6_lockstep_grp_fsm #(
         .GroupSize     (GroupSize),
         .SigWidth      (SigWidth),
         .SetbackCycles (SetbackCycles),
         .SyncTimeout   (SyncTimeout),
         .CntWidth      (CntWidth)
      ) u_fsm (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .lockstep_i  (grp_lockstep_i[g]),
         .cmp_valid_i (cmp_valid_i[g*GroupSize +: GroupSize]),
         .cmp_sig_i   (cmp_sig_i[g*GroupSize*SigWidth +: GroupSize*SigWidth]),
         .sync_req_i  (sync_req_i[g*GroupSize +: GroupSize]),
         .setback_o   (setback),
         .state_o     (state),
         .error_o     (grp_error_o[g]),
         .faulty_o    (grp_faulty_o[2*g +: 2]),
         .failure_o   (grp_failure_o[g]),
         .cnt_o       (mismatch_cnt_o[g*CntWidth +: CntWidth])
      );

      assign core_setback_o[g*GroupSize +: GroupSize] = {GroupSize{setback}};
      assign grp_state_o[2*g +: 2]                    = state;
   end

endmodule

// File: tb/tb_cva6_lockstep_ctrl.sv
// Directed bench for cva6_lockstep_ctrl: DMR (defaults), TMR and narrow-counter instances on one clock.
module tb_cva6_lockstep_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // A: 4 harts DMR, default parameters
   logic [1:0]   a_ls;
   logic [3:0]   a_vld, a_sync, a_sb, a_state, a_faulty;
   logic [255:0] a_sig;
   logic [1:0]   a_err, a_fail;
   logic [15:0]  a_cnt;

   // B: 3 harts TMR
   logic [0:0]   b_ls, b_err, b_fail;
   logic [2:0]   b_vld, b_sync, b_sb;
   logic [191:0] b_sig;
   logic [1:0]   b_state, b_faulty;
   logic [7:0]   b_cnt;

   // C: 4 harts DMR, 2-bit counters, short timers
   logic [1:0]   c_ls;
   logic [3:0]   c_vld, c_sync, c_sb, c_state, c_faulty;
   logic [255:0] c_sig;
   logic [1:0]   c_err, c_fail;
   logic [3:0]   c_cnt;

   cva6_lockstep_ctrl u_dut_a (
      .clk_i(clk), .rst_i(rst), .grp_lockstep_i(a_ls), .cmp_valid_i(a_vld), .cmp_sig_i(a_sig),
      .sync_req_i(a_sync), .core_setback_o(a_sb), .grp_state_o(a_state), .grp_error_o(a_err),
      .grp_faulty_o(a_faulty), .grp_failure_o(a_fail), .mismatch_cnt_o(a_cnt));

   cva6_lockstep_ctrl #(.NumHarts(3), .GroupSize(3), .SetbackCycles(4), .SyncTimeout(32)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .grp_lockstep_i(b_ls), .cmp_valid_i(b_vld), .cmp_sig_i(b_sig),
      .sync_req_i(b_sync), .core_setback_o(b_sb), .grp_state_o(b_state), .grp_error_o(b_err),
      .grp_faulty_o(b_faulty), .grp_failure_o(b_fail), .mismatch_cnt_o(b_cnt));

   cva6_lockstep_ctrl #(.CntWidth(2), .SetbackCycles(2), .SyncTimeout(16)) u_dut_c (
      .clk_i(clk), .rst_i(rst), .grp_lockstep_i(c_ls), .cmp_valid_i(c_vld), .cmp_sig_i(c_sig),
      .sync_req_i(c_sync), .core_setback_o(c_sb), .grp_state_o(c_state), .grp_error_o(c_err),
      .grp_faulty_o(c_faulty), .grp_failure_o(c_fail), .mismatch_cnt_o(c_cnt));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_a(input int h, input logic [63:0] v);
      a_sig[h*64 +: 64] = v;
   endtask
   task automatic set_b(input int h, input logic [63:0] v);
      b_sig[h*64 +: 64] = v;
   endtask
   task automatic set_c(input int h, input logic [63:0] v);
      c_sig[h*64 +: 64] = v;
   endtask

   logic seen;
   logic ok;

   initial begin
      rst = 1'b1;
      a_ls = 2'b11; a_vld = '0; a_sync = '0; a_sig = '0;
      b_ls = 1'b1;  b_vld = '0; b_sync = '0; b_sig = '0;
      c_ls = 2'b11; c_vld = '0; c_sync = '0; c_sig = '0;
      tick(2);

      // 1. reset values, then 100 cycles of agreeing signatures
      chk("rst_state_a",   64'(a_state),  64'h0);
      chk("rst_setback_a", 64'(a_sb),     64'h0);
      chk("rst_faulty_a",  64'(a_faulty), 64'hF);
      chk("rst_fail_a",    64'(a_fail),   64'h0);
      chk("rst_cnt_a",     64'(a_cnt),    64'h0);
      chk("rst_faulty_b",  64'(b_faulty), 64'h3);
      for (int h = 0; h < 4; h++) begin
         set_a(h, 64'hA5);
         set_c(h, 64'hA5);
      end
      for (int h = 0; h < 3; h++) set_b(h, 64'h5);
      a_vld = 4'hF; b_vld = 3'h7; c_vld = 4'hF;
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         tick();
         seen = seen | (|a_err) | (|b_err) | (|c_err);
      end
      chk("equal_no_err",  64'(seen),    64'h0);
      chk("equal_state_a", 64'(a_state), 64'h0);
      chk("equal_cnt_a",   64'(a_cnt),   64'h0);

      // 2. DMR mismatch in group 0, recovery via sync at t+20
      set_a(1, 64'hA4);
      tick();
      chk("mm_err_pulse", 64'(a_err),   64'h1);
      chk("mm_state_sb",  64'(a_state), 64'h1);
      chk("mm_setback",   64'(a_sb),    64'h3);
      chk("mm_cnt",       64'(a_cnt),   64'h1);
      set_a(1, 64'hA5);
      tick();
      chk("mm_err_1cyc",  64'(a_err),   64'h0);
      ok = 1'b1;
      for (int k = 2; k <= 8; k++) begin
         if (a_sb !== 4'b0011 || a_state !== 4'h1) ok = 1'b0;
         if (k < 8) tick();
      end
      chk("mm_setback_hold", 64'(ok), 64'h1);
      tick();
      chk("mm_setback_rel", 64'(a_sb),    64'h0);
      chk("mm_resync",      64'(a_state), 64'h2);
      tick(11);
      chk("mm_resync_wait", 64'(a_state), 64'h2);
      a_sync = 4'b0011;
      tick();
      a_sync = 4'b0000;
      chk("mm_run",         64'(a_state), 64'h0);
      chk("mm_cnt_after",   64'(a_cnt),   64'h1);
      tick();
      chk("mm_resume_ok",   64'(a_err),   64'h0);

      // 3. group 1 mismatch with no sync: timeout to failure, then lockstep drop
      set_a(3, 64'h0);
      tick();
      chk("to_err",     64'(a_err),   64'h2);
      chk("to_setback", 64'(a_sb),    64'hC);
      tick(8);
      chk("to_resync",  64'(a_state), 64'h8);
      tick(1023);
      chk("to_pre_fail",  64'(a_state), 64'h8);
      chk("to_pre_flag",  64'(a_fail),  64'h0);
      tick();
      chk("to_fail",      64'(a_state), 64'hC);
      chk("to_fail_flag", 64'(a_fail),  64'h2);
      chk("to_fail_sb",   64'(a_sb),    64'h0);
      tick(5);
      chk("to_sticky",    64'(a_fail),  64'h2);
      chk("to_ignored",   64'(a_err),   64'h0);
      chk("to_cnt",       64'(a_cnt),   64'h0101);
      a_ls = 2'b01;
      tick();
      chk("drop_state",   64'(a_state),  64'h0);
      chk("drop_fail",    64'(a_fail),   64'h0);
      chk("drop_faulty",  64'(a_faulty), 64'hF);
      set_a(3, 64'hA5);
      a_ls = 2'b11;
      tick(2);

      // 4. TMR: single outvoted hart, then no majority
      set_b(1, 64'h7);
      tick();
      chk("tmr_faulty",  64'(b_faulty), 64'h1);
      chk("tmr_err",     64'(b_err),    64'h1);
      chk("tmr_sb",      64'(b_sb),     64'h7);
      set_b(1, 64'h5);
      tick(4);
      chk("tmr_resync",  64'(b_state),  64'h2);
      b_sync = 3'b111;
      tick();
      b_sync = 3'b000;
      chk("tmr_run",     64'(b_state),  64'h0);
      chk("tmr_hold",    64'(b_faulty), 64'h1);
      set_b(0, 64'h1); set_b(1, 64'h2); set_b(2, 64'h3);
      tick();
      chk("tmr_nomaj_state",  64'(b_state),  64'h3);
      chk("tmr_nomaj_faulty", 64'(b_faulty), 64'h3);
      chk("tmr_nomaj_fail",   64'(b_fail),   64'h1);
      chk("tmr_nomaj_sb",     64'(b_sb),     64'h0);
      chk("tmr_cnt",          64'(b_cnt),    64'h2);
      tick(3);
      chk("tmr_fail_sticky",  64'(b_fail),   64'h1);

      // 5. 2-bit counter saturation with five recovered mismatches
      seen = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         set_c(1, 64'hA4);
         tick();
         if (k == 1) chk("sat_sb_first", 64'(c_sb), 64'h3);
         set_c(1, 64'hA5);
         tick();
         if (k == 1) chk("sat_sb_last", 64'(c_sb), 64'h3);
         tick();
         if (k == 1) chk("sat_sb_rel", 64'(c_sb), 64'h0);
         chk("sat_resync", 64'(c_state), 64'h2);
         c_sync = 4'b0011;
         tick();
         c_sync = 4'b0000;
         chk("sat_cnt", 64'(c_cnt[1:0]), 64'((k > 3) ? 3 : k));
         seen = seen | c_err[1];
      end
      chk("sat_grp1_cnt",   64'(c_cnt[3:2]),   64'h0);
      chk("sat_grp1_state", 64'(c_state[3:2]), 64'h0);
      chk("sat_grp1_err",   64'(seen),         64'h0);

      // 6. lockstep drop vs mismatch, drop mid-setback, reset mid-resync
      set_a(1, 64'hA4);
      a_ls = 2'b10;
      tick();
      chk("dropmm_err",   64'(a_err),   64'h0);
      chk("dropmm_state", 64'(a_state), 64'h0);
      chk("dropmm_cnt",   64'(a_cnt),   64'h0101);
      set_a(1, 64'hA5);
      a_ls = 2'b11;
      tick();
      set_a(1, 64'hA4);
      tick();
      chk("midsb_state", 64'(a_state), 64'h1);
      chk("midsb_cnt",   64'(a_cnt),   64'h0102);
      set_a(1, 64'hA5);
      tick(2);
      a_ls = 2'b10;
      tick();
      chk("midsb_release", 64'(a_sb),    64'h0);
      chk("midsb_run",     64'(a_state), 64'h0);
      a_ls = 2'b11;
      tick();
      set_a(0, 64'h1);
      tick();
      set_a(0, 64'hA5);
      tick(8);
      chk("rr_resync", 64'(a_state), 64'h2);
      chk("rr_cnt",    64'(a_cnt),   64'h0103);
      tick(3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rr_state",    64'(a_state),  64'h0);
      chk("rr_cnt_rst",  64'(a_cnt),    64'h0);
      chk("rr_faulty",   64'(a_faulty), 64'hF);
      chk("rr_b_state",  64'(b_state),  64'h0);
      chk("rr_b_fail",   64'(b_fail),   64'h0);
      chk("rr_b_faulty", 64'(b_faulty), 64'h3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
